rat_reduce: RTL and testbench

RAT_REDUCE -- requirements
Module: rat_reduce

---
 rtl/rat_pkg.sv | 16 +
 rtl/rat_udiv.sv | 57 +++++
 rtl/rat_reduce.sv | 154 +++++++++++++++
 tb/tb_rat_reduce.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rat_pkg.sv
// Shared definitions for the rational-arithmetic pipeline stages:
// default operand width and the reduce-stage state encoding.
package rat_pkg;

    localparam int RAT_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_NORM    = 3'd1,
        ST_GCD     = 3'd2,
        ST_DIV_NUM = 3'd3,
        ST_DIV_DEN = 3'd4,
        ST_DONE    = 3'd5
    } rat_state_t;

endpackage

// File: rtl/rat_udiv.sv
// Unsigned restoring divider: a one-cycle start pulse loads the operands,
// then WIDTH iterations follow; done pulses for one cycle with the quotient.
module rat_udiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    count;
    logic             busy;
    logic [WIDTH-1:0] rem;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // The remainder stays below the divisor, so bit WIDTH of diff is the borrow.
    assign shifted = {rem, quotient[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor};

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            busy     <= 1'b0;
            rem      <= '0;
            quotient <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem      <= '0;
                quotient <= dividend;
                count    <= CW'(WIDTH);
                busy     <= 1'b1;
            end else if (busy) begin
                if (!diff[WIDTH]) begin
                    rem      <= diff[WIDTH-1:0];
                    quotient <= {quotient[WIDTH-2:0], 1'b1};
                end else begin
                    rem      <= shifted[WIDTH-1:0];
                    quotient <= {quotient[WIDTH-2:0], 1'b0};
                end
                count <= count - CW'(1);
                if (count == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rat_reduce.sv
// Normalization stage: reduces a signed fraction to lowest terms with a
// positive denominator, using a binary GCD followed by two exact divisions.
module rat_reduce
    import rat_pkg::*;
#(
    parameter int WIDTH = RAT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_num,
    input  logic [WIDTH-1:0] in_den,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_num,
    output logic [WIDTH-1:0] out_den,
    output logic             err
);
    localparam int               KW      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    rat_state_t       state;
    logic [WIDTH-1:0] num_q, den_q;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] ga, gb, g;
    logic [WIDTH-1:0] q_num;
    logic [KW-1:0]    k;
    logic             neg;
    logic             start_q;
    logic             div_done;
    logic [WIDTH-1:0] div_dividend;
    logic [WIDTH-1:0] div_quotient;
    logic [WIDTH-1:0] abs_num, abs_den;

    // Valid/ready: a transfer happens on a rising edge where both are 1;
    // out_* is held stable while out_valid=1 and out_ready=0.
    assign in_ready = (state == ST_IDLE) && !rst;

    assign abs_num      = num_q[WIDTH-1] ? -num_q : num_q;
    assign abs_den      = den_q[WIDTH-1] ? -den_q : den_q;
    assign div_dividend = (state == ST_DIV_DEN) ? mag_b : mag_a;

    rat_udiv #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (start_q),
        .dividend (div_dividend),
        .divisor  (g),
        .done     (div_done),
        .quotient (div_quotient)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            num_q     <= '0;
            den_q     <= '0;
            mag_a     <= '0;
            mag_b     <= '0;
            ga        <= '0;
            gb        <= '0;
            g         <= '0;
            q_num     <= '0;
            k         <= '0;
            neg       <= 1'b0;
            start_q   <= 1'b0;
            out_valid <= 1'b0;
            out_num   <= '0;
            out_den   <= '0;
            err       <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        num_q <= in_num;
                        den_q <= in_den;
                        state <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    if (den_q == '0 || den_q == MIN_VAL) begin
                        out_num   <= '0;
                        out_den   <= '0;
                        err       <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else if (num_q == '0) begin
                        out_num   <= '0;
                        out_den   <= ONE;
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        neg   <= num_q[WIDTH-1] ^ den_q[WIDTH-1];
                        mag_a <= abs_num;
                        mag_b <= abs_den;
                        ga    <= abs_num;
                        gb    <= abs_den;
                        k     <= '0;
                        state <= ST_GCD;
                    end
                end
                ST_GCD: begin
                    // Odd-odd steps subtract and halve together so each cycle
                    // drops at least one bit from the pair.
                    if (ga == gb) begin
                        g       <= ga << k;
                        start_q <= 1'b1;
                        state   <= ST_DIV_NUM;
                    end else if (!ga[0] && !gb[0]) begin
                        ga <= ga >> 1;
                        gb <= gb >> 1;
                        k  <= k + KW'(1);
                    end else if (!ga[0]) begin
                        ga <= ga >> 1;
                    end else if (!gb[0]) begin
                        gb <= gb >> 1;
                    end else if (ga > gb) begin
                        ga <= (ga - gb) >> 1;
                    end else begin
                        gb <= (gb - ga) >> 1;
                    end
                end
                ST_DIV_NUM: begin
                    if (div_done) begin
                        q_num   <= div_quotient;
                        start_q <= 1'b1;
                        state   <= ST_DIV_DEN;
                    end
                end
                ST_DIV_DEN: begin
                    if (div_done) begin
                        out_num   <= neg ? -q_num : q_num;
                        out_den   <= div_quotient;
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rat_reduce.sv
// Bench for rat_reduce: directed vector table, stall and reset corner cases,
// and randomized fractions checked against a Euclid-based reference model.
module tb_rat_reduce;
    localparam int          W       = 32;
    localparam int          LAT_MAX = 5 * W + 4;
    localparam logic [W-1:0] MINV   = {1'b1, {(W-1){1'b0}}};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready;
    logic [W-1:0] in_num, in_den;
    logic         out_valid, out_ready;
    logic [W-1:0] out_num, out_den;
    logic         err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rat_reduce #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_num    (in_num),
        .in_den    (in_den),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_num   (out_num),
        .out_den   (out_den),
        .err       (err)
    );

    typedef struct {
        logic [W-1:0] num;
        logic [W-1:0] den;
        logic [W-1:0] e_num;
        logic [W-1:0] e_den;
        logic         e_err;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [W:0] got, input logic [W:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: plain signed arithmetic with Euclid's remainder GCD.
    function automatic void model(input logic [W-1:0] n, input logic [W-1:0] d,
                                  output logic [W-1:0] rn, output logic [W-1:0] rd,
                                  output logic re);
        longint sn, sd, a, b, x, y, t, qn, qd;
        sn = longint'($signed(n));
        sd = longint'($signed(d));
        if (d == '0 || d == MINV) begin
            rn = '0; rd = '0; re = 1'b1;
        end else if (n == '0) begin
            rn = '0; rd = W'(1); re = 1'b0;
        end else begin
            a = (sn < 0) ? -sn : sn;
            b = (sd < 0) ? -sd : sd;
            x = a;
            y = b;
            while (y != 0) begin
                t = x % y;
                x = y;
                y = t;
            end
            qn = a / x;
            qd = b / x;
            rn = ((sn < 0) != (sd < 0)) ? W'(-qn) : W'(qn);
            rd = W'(qd);
            re = 1'b0;
        end
    endfunction

    // Called just after a negedge; returns just after the negedge that
    // follows the output handshake.
    task automatic run_case(input logic [W-1:0] n, input logic [W-1:0] d,
                            output logic [W-1:0] rn, output logic [W-1:0] rd,
                            output logic re, output int lat, output bit ok);
        int waited;
        rn = '0; rd = '0; re = 1'b0; lat = 0; ok = 1'b1;
        in_num   = n;
        in_den   = d;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < LAT_MAX + 20) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            ok = 1'b0;
            return;
        end
        rn = out_num;
        rd = out_den;
        re = err;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_one(input string tag, input logic [W-1:0] n, input logic [W-1:0] d,
                            input logic [W-1:0] en, input logic [W-1:0] ed, input logic ee);
        logic [W-1:0] rn, rd;
        logic         re;
        int           lat;
        bit           ok;
        run_case(n, d, rn, rd, re, lat, ok);
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s.timeout: no handshake within %0d cycles", tag, LAT_MAX + 20);
        end else begin
            check({tag, ".num"}, rn, en);
            check({tag, ".den"}, rd, ed);
            check({tag, ".err"}, re, ee);
            n_cmp++;
            if (lat > LAT_MAX) begin
                n_fail++;
                $display("FAIL %s.latency: got %0d cycles, required <= %0d", tag, lat, LAT_MAX);
            end
            check({tag, ".valid_clear"}, out_valid, 1'b0);
            check({tag, ".ready_back"}, in_ready, 1'b1);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] n, d, en, ed;
        logic         ee;
        int           waited;
        bit           saw_valid;

        vecs[0]  = '{W'(6), W'(8), W'(3), W'(4), 1'b0};
        vecs[1]  = '{W'(-12), W'(-18), W'(2), W'(3), 1'b0};
        vecs[2]  = '{W'(12), W'(-18), W'(-2), W'(3), 1'b0};
        vecs[3]  = '{W'(0), W'(-7), W'(0), W'(1), 1'b0};
        vecs[4]  = '{W'(5), W'(0), W'(0), W'(0), 1'b1};
        vecs[5]  = '{32'h8000_0000, W'(2), 32'hC000_0000, W'(1), 1'b0};
        vecs[6]  = '{W'(1), 32'h8000_0000, W'(0), W'(0), 1'b1};
        vecs[7]  = '{W'(35), W'(49), W'(5), W'(7), 1'b0};
        vecs[8]  = '{W'(-1), W'(-1), W'(1), W'(1), 1'b0};
        vecs[9]  = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0};
        vecs[10] = '{W'(0), W'(0), W'(0), W'(0), 1'b1};
        vecs[11] = '{W'(100), W'(-7), W'(-100), W'(7), 1'b0};
        vecs[12] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, W'(1), W'(1), 1'b0};
        vecs[13] = '{W'(48), W'(18), W'(8), W'(3), 1'b0};

        // Clock/reset
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_num = '0; in_den = '0;
        repeat (3) @(negedge clk);
        check("reset.in_ready", in_ready, 1'b0);
        check("reset.out_valid", out_valid, 1'b0);
        check("reset.err", err, 1'b0);
        check("reset.out_num", out_num, '0);
        check("reset.out_den", out_den, '0);
        rst = 1'b0;
        @(negedge clk);
        check("reset.in_ready_after", in_ready, 1'b1);

        for (int i = 0; i < 14; i++)
            test_one($sformatf("vec[%0d]", i), vecs[i].num, vecs[i].den,
                     vecs[i].e_num, vecs[i].e_den, vecs[i].e_err);

        // Stall in DONE with a distracting in_valid held high while busy.
        check("stall.in_ready_pre", in_ready, 1'b1);
        in_num = W'(6); in_den = W'(8); in_valid = 1'b1;
        @(negedge clk);
        in_num = W'(99); in_den = W'(3);
        waited = 0;
        while (!out_valid && waited < LAT_MAX + 20) begin
            @(negedge clk);
            waited++;
        end
        check("stall.reached_done", out_valid, 1'b1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("stall[%0d].out_valid", c), out_valid, 1'b1);
            check($sformatf("stall[%0d].out_num", c), out_num, W'(3));
            check($sformatf("stall[%0d].out_den", c), out_den, W'(4));
            check($sformatf("stall[%0d].err", c), err, 1'b0);
            check($sformatf("stall[%0d].in_ready", c), in_ready, 1'b0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("stall.valid_clear", out_valid, 1'b0);
        check("stall.in_ready_next", in_ready, 1'b1);

        // Reset while the GCD of 35/49 is in progress.
        in_num = W'(35); in_den = W'(49); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort.out_valid", out_valid, 1'b0);
        check("abort.in_ready_in_rst", in_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("abort.in_ready_after", in_ready, 1'b1);
        saw_valid = 1'b0;
        for (int c = 0; c < LAT_MAX; c++) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check("abort.no_output", saw_valid, 1'b0);
        test_one("abort.retry", W'(35), W'(49), W'(5), W'(7), 1'b0);

        // Randomized fractions against the reference model.
        for (int i = 0; i < 150; i++) begin
            int mode, x, y, f;
            mode = $urandom_range(0, 3);
            case (mode)
                0: begin
                    n = $urandom;
                    d = $urandom;
                end
                1: begin
                    x = $urandom_range(0, 200);
                    y = $urandom_range(0, 200);
                    n = W'(x - 100);
                    d = W'(y - 100);
                end
                2: begin
                    f = $urandom_range(1, 1000);
                    x = $urandom_range(0, 2000);
                    y = $urandom_range(0, 2000);
                    n = W'((x - 1000) * f);
                    d = W'((y - 1000) * f);
                end
                default: begin
                    n = W'(1) << $urandom_range(0, 30);
                    if ($urandom_range(0, 1) == 1) n = -n;
                    d = W'(1) << $urandom_range(0, 31);
                end
            endcase
            model(n, d, en, ed, ee);
            test_one($sformatf("rand[%0d] %0h/%0h", i, n, d), n, d, en, ed, ee);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
